// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Holds the shared constants and pointer-width helpers for the sync_fifo_cs
// FIFO and its pointer sub-module.
//   DATA_W_DEF : default data word width
//   DEPTH_DEF  : default number of storage entries
//   addr_w()   : bits needed to index the storage array
//   ptr_w()    : pointer width, which is the index bits plus one wrap bit
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int DEPTH_DEF  = 8;

   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// -----------------------------------------------------------------------------
// sync_fifo_ptr
// A FIFO pointer register. It counts up on each accepted operation and wraps
// by natural binary rollover. The MSB toggles once per lap of the storage
// array and acts as the wrap bit.
// Ports:
//   i_clk  : rising-edge clock
//   i_rst  : synchronous active-high reset, which clears the pointer
//   i_inc  : advance the pointer by one
//   o_ptr  : current pointer value, including the wrap bit
// -----------------------------------------------------------------------------
module sync_fifo_ptr #(
   parameter int PTR_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_inc,
   output logic [PTR_W-1:0] o_ptr
);

   logic [PTR_W-1:0] r_ptr;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_ptr <= '0;
      else if (i_inc)
         r_ptr <= r_ptr + PTR_W'(1);
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/sync_fifo_cs.sv
// -----------------------------------------------------------------------------
// sync_fifo_cs
// A single-clock FIFO with chip-select gating, registered read data, and
// combinational full and empty flags that are derived from the two pointers.
// Optional macro FIFO_STATUS_EN adds the count and err status outputs.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset. It clears both pointers and
//              data_out; memory contents are kept.
//   cs       : chip select. When it is low, wr_enb and rd_enb are ignored.
//   wr_enb   : write request
//   rd_enb   : read request
//   data_in  : write data
//   data_out : registered read data. It holds its value when no read is
//              accepted.
//   f / e    : full / empty flags
//   count    : (FIFO_STATUS_EN) occupancy, from 0 to fifo_depth
//   err      : (FIFO_STATUS_EN) sticky flag for a dropped write or an
//              ignored read
// -----------------------------------------------------------------------------
module sync_fifo_cs
   import sync_fifo_pkg::*;
#(
   parameter int data_depth = DATA_W_DEF,
   parameter int fifo_depth = DEPTH_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cs,
   input  logic                      wr_enb,
   input  logic                      rd_enb,
   input  logic [data_depth-1:0]     data_in,
   output logic [data_depth-1:0]     data_out,
`ifdef FIFO_STATUS_EN
   output logic [ptr_w(fifo_depth)-1:0] count,
   output logic                      err,
`endif
   output logic                      f,
   output logic                      e
);

   localparam int ADDR_W = addr_w(fifo_depth);
   localparam int PTR_W  = ptr_w(fifo_depth);

   logic [data_depth-1:0] r_mem [fifo_depth];
   logic [data_depth-1:0] r_data_out;
   logic [PTR_W-1:0]      w_wr_ptr;
   logic [PTR_W-1:0]      w_rd_ptr;
   logic                  w_rd_acc;
   logic                  w_wr_acc;

   assign e = (w_wr_ptr == w_rd_ptr);
   assign f = (w_wr_ptr[PTR_W-1] != w_rd_ptr[PTR_W-1]) &&
              (w_wr_ptr[ADDR_W-1:0] == w_rd_ptr[ADDR_W-1:0]);

   assign w_rd_acc = cs && rd_enb && !e;
   // When the FIFO is full, a read accepted in the same cycle frees the slot
   // the write targets. The write is therefore taken as well. The read gets
   // the old word because memory updates non-blocking.
   assign w_wr_acc = cs && wr_enb && (!f || w_rd_acc);

   sync_fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
      .i_clk (clk),
      .i_rst (rst),
      .i_inc (w_wr_acc),
      .o_ptr (w_wr_ptr)
   );

   sync_fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
      .i_clk (clk),
      .i_rst (rst),
      .i_inc (w_rd_acc),
      .o_ptr (w_rd_ptr)
   );

   // Storage is not reset. Stale entries are never visible because the
   // pointers gate every access.
   always_ff @(posedge clk) begin
      if (!rst && w_wr_acc)
         r_mem[w_wr_ptr[ADDR_W-1:0]] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_data_out <= '0;
      else if (w_rd_acc)
         r_data_out <= r_mem[w_rd_ptr[ADDR_W-1:0]];
   end

   assign data_out = r_data_out;

`ifdef FIFO_STATUS_EN
   logic r_err;
   logic w_wr_drop;
   logic w_rd_drop;

   assign w_wr_drop = cs && wr_enb && !w_wr_acc;
   assign w_rd_drop = cs && rd_enb && !w_rd_acc;

   always_ff @(posedge clk) begin
      if (rst)
         r_err <= 1'b0;
      else if (w_wr_drop || w_rd_drop)
         r_err <= 1'b1;
   end

   assign count = w_wr_ptr - w_rd_ptr;
   assign err   = r_err;
`endif

endmodule

// File: tb/tb_sync_fifo_cs.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_cs
// Directed testbench for sync_fifo_cs using the default parameters
// (32-bit words, 8 entries). Define FIFO_STATUS_EN to also cover the count
// and err outputs.
// -----------------------------------------------------------------------------
module tb_sync_fifo_cs;

   logic        clk = 1'b0;
   logic        rst;
   logic        cs;
   logic        wr_enb;
   logic        rd_enb;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        f;
   logic        e;
`ifdef FIFO_STATUS_EN
   logic [3:0]  count;
   logic        err;
`endif

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sync_fifo_cs dut (
      .clk      (clk),
      .rst      (rst),
      .cs       (cs),
      .wr_enb   (wr_enb),
      .rd_enb   (rd_enb),
      .data_in  (data_in),
      .data_out (data_out),
`ifdef FIFO_STATUS_EN
      .count    (count),
      .err      (err),
`endif
      .f        (f),
      .e        (e)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Apply one set of inputs across a rising edge, then settle 1ns past it.
   task automatic cyc(input logic c, input logic w, input logic r, input logic [31:0] d);
      cs = c; wr_enb = w; rd_enb = r; data_in = d;
      @(posedge clk);
      #1;
      cs = 1'b0; wr_enb = 1'b0; rd_enb = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 32'd0);
      rst = 1'b0;
   endtask

   int unsigned p3;

   initial begin
      rst = 1'b0; cs = 1'b0; wr_enb = 1'b0; rd_enb = 1'b0; data_in = '0;
      #2;
      do_reset();
      chk("rst_dout", data_out, 32'd0);
      chk("rst_e", 32'(e), 32'd1);
      chk("rst_f", 32'(f), 32'd0);

      // Write 1, 10, 100, then read them back in order
      cyc(1'b1, 1'b1, 1'b0, 32'd1);
      chk("w1_e", 32'(e), 32'd0);
      cyc(1'b1, 1'b1, 1'b0, 32'd10);
      cyc(1'b1, 1'b1, 1'b0, 32'd100);
      chk("w3_f", 32'(f), 32'd0);
      cyc(1'b1, 1'b0, 1'b1, 32'd0);
      chk("r1", data_out, 32'd1);
      cyc(1'b1, 1'b0, 1'b1, 32'd0);
      chk("r2", data_out, 32'd10);
      cyc(1'b1, 1'b0, 1'b1, 32'd0);
      chk("r3", data_out, 32'd100);
      chk("r3_e", 32'(e), 32'd1);
      chk("r3_f", 32'(f), 32'd0);

      // Interleave writes and reads of powers of two
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 32'd1 << i);
         chk("pow2_w_e", 32'(e), 32'd0);
         cyc(1'b1, 1'b0, 1'b1, 32'd0);
         chk("pow2_r", data_out, 32'd1 << i);
         chk("pow2_r_e", 32'(e), 32'd1);
      end

      // Fill with powers of three, drop a write of 999, then drain
      p3 = 1;
      for (int i = 0; i < 8; i++) begin
         chk("p3_pre_f", 32'(f), 32'd0);
         cyc(1'b1, 1'b1, 1'b0, p3);
         p3 = p3 * 3;
      end
      chk("full_f", 32'(f), 32'd1);
`ifdef FIFO_STATUS_EN
      chk("full_count", 32'(count), 32'd8);
      chk("full_err", 32'(err), 32'd0);
`endif
      cyc(1'b1, 1'b1, 1'b0, 32'd999);
      chk("drop_f", 32'(f), 32'd1);
`ifdef FIFO_STATUS_EN
      chk("drop_count", 32'(count), 32'd8);
      chk("drop_err", 32'(err), 32'd1);
`endif
      p3 = 1;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b0, 1'b1, 32'd0);
         chk("p3_r", data_out, p3);
         chk("p3_r_f", 32'(f), 32'd0);
         p3 = p3 * 3;
      end
      chk("p3_end_e", 32'(e), 32'd1);

      // A read while empty must not change data_out or the flags
      cyc(1'b1, 1'b0, 1'b1, 32'd0);
      chk("empty_rd_dout", data_out, 32'd2187);
      chk("empty_rd_e", 32'(e), 32'd1);
      // Simultaneous write and read while empty: the write lands, and the
      // read is ignored
      cyc(1'b1, 1'b1, 1'b1, 32'd77);
      chk("empty_wr_rd_dout", data_out, 32'd2187);
      chk("empty_wr_rd_e", 32'(e), 32'd0);
      cyc(1'b1, 1'b0, 1'b1, 32'd0);
      chk("empty_wr_rd_r", data_out, 32'd77);
      chk("empty_wr_rd_e2", 32'(e), 32'd1);

      // Full FIFO with a simultaneous read and write
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 32'(10 + i));
      chk("fill2_f", 32'(f), 32'd1);
      cyc(1'b1, 1'b1, 1'b1, 32'd55);
      chk("full_rw_dout", data_out, 32'd10);
      chk("full_rw_f", 32'(f), 32'd1);
      for (int i = 1; i < 8; i++) begin
         cyc(1'b1, 1'b0, 1'b1, 32'd0);
         chk("full_rw_drain", data_out, 32'(10 + i));
      end
      cyc(1'b1, 1'b0, 1'b1, 32'd0);
      chk("full_rw_last", data_out, 32'd55);
      chk("full_rw_end_e", 32'(e), 32'd1);

      // With cs low, held requests must not change state
      do_reset();
      chk("rst2_dout", data_out, 32'd0);
      cyc(1'b1, 1'b1, 1'b0, 32'd5);
      cyc(1'b1, 1'b1, 1'b0, 32'd6);
      cyc(1'b1, 1'b0, 1'b1, 32'd0);
      chk("cs_pre_dout", data_out, 32'd5);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 32'd123);
      chk("cs0_dout", data_out, 32'd5);
      chk("cs0_e", 32'(e), 32'd0);
      chk("cs0_f", 32'(f), 32'd0);
`ifdef FIFO_STATUS_EN
      chk("cs0_count", 32'(count), 32'd1);
      chk("cs0_err", 32'(err), 32'd0);
`endif
      cyc(1'b1, 1'b0, 1'b1, 32'd0);
      chk("cs_post_r", data_out, 32'd6);
      chk("cs_post_e", 32'(e), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
